biquad_cascade: RTL and testbench

BIQUAD_CASCADE -- requirements
Module: biquad_cascade

---
 rtl/biquad_cascade.sv | 163 ++++++++++++++++
 tb/tb_biquad_cascade.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/biquad_cascade.sv
// Cascade of N_SECT Direct Form I biquad sections sharing one multiplier.
// Each sample takes 5 MAC cycles plus 1 write-back cycle per section.
module biquad_cascade #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int FRAC_BITS = 22,
  parameter int N_SECT    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_coef_we,
  input  logic [7:0]        i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_wdata,
  input  logic              i_clear,
  output logic              o_sat
);

  localparam int N_COEF = 5 * N_SECT;
  localparam int CI_W   = $clog2(N_COEF);
  localparam int SEC_W  = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC_BITS;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  state_t state, state_nxt;

  logic [SEC_W-1:0]         sec;
  logic [2:0]               tap;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef [N_COEF];
  logic signed [DATA_W-1:0] x1 [N_SECT];
  logic signed [DATA_W-1:0] x2 [N_SECT];
  logic signed [DATA_W-1:0] y1 [N_SECT];
  logic signed [DATA_W-1:0] y2 [N_SECT];

  logic [CI_W-1:0]          coef_idx;
  logic signed [DATA_W-1:0] operand;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y;
  logic                     sat_now;
  logic                     last_sect;
  logic                     accept;
  logic                     coef_wr;
  logic                     clear_hist;

  assign o_in_ready = (state == IDLE) && !i_clear;
  assign o_valid    = (state == OUT);
  assign accept     = i_valid && o_in_ready;
  assign coef_wr    = (state == IDLE) && i_coef_we && (i_coef_addr < 8'(N_COEF));
  assign clear_hist = (state == IDLE) && i_clear;
  assign last_sect  = (sec == SEC_W'(N_SECT - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves a latch.
  always_comb begin
    coef_idx = CI_W'(int'(sec) * 5 + int'(tap));
    operand  = x_cur;
    case (tap)
      3'd1:    operand = x1[sec];
      3'd2:    operand = x2[sec];
      3'd3:    operand = y1[sec];
      3'd4:    operand = y2[sec];
      default: operand = x_cur;
    endcase
  end

  assign prod     = PROD_W'(operand) * PROD_W'(coef[coef_idx]);
  assign prod_ext = ACC_W'(prod);
  // Feedback taps a1/a2 are subtracted.
  assign acc_nxt  = (tap >= 3'd3) ? acc - prod_ext : acc + prod_ext;
  assign shifted  = acc >>> FRAC_BITS;
  assign sat_now  = (shifted > Y_MAX) || (shifted < Y_MIN);
  assign y        = (shifted > Y_MAX) ? Y_MAX[DATA_W-1:0] :
                    (shifted < Y_MIN) ? Y_MIN[DATA_W-1:0] : shifted[DATA_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == 3'd4) state_nxt = WB;
      WB:      state_nxt = last_sect ? OUT : MAC;
      OUT:     if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: coefficient and history arrays are reset because reset must restore passthrough filters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sec    <= '0;
      tap    <= '0;
      x_cur  <= '0;
      acc    <= '0;
      o_data <= '0;
      o_sat  <= 1'b0;
      for (int i = 0; i < N_COEF; i++) coef[i] <= (i % 5 == 0) ? COEF_ONE : '0;
      for (int s = 0; s < N_SECT; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_wr) coef[i_coef_addr[CI_W-1:0]] <= i_coef_wdata;
          if (clear_hist) begin
            o_sat <= 1'b0;
            for (int s = 0; s < N_SECT; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end
          if (accept) begin
            x_cur <= i_data;
            sec   <= '0;
            tap   <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          tap <= tap + 3'd1;
        end
        WB: begin
          x2[sec] <= x1[sec];
          x1[sec] <= x_cur;
          y2[sec] <= y1[sec];
          y1[sec] <= y;
          x_cur   <= y;
          acc     <= '0;
          tap     <= '0;
          if (sat_now) o_sat <= 1'b1;
          if (last_sect) o_data <= y;
          else           sec    <= sec + SEC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed bench for biquad_cascade: vector table of coefficient/sample steps
// plus hand sequences for output stall and mid-flight reset.
module tb_biquad_cascade;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_in_ready;
  logic [23:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [23:0] o_data;
  logic        i_coef_we = 1'b0;
  logic [7:0]  i_coef_addr = '0;
  logic [23:0] i_coef_wdata = '0;
  logic        i_clear = 1'b0;
  logic        o_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  biquad_cascade dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_in_ready   (o_in_ready),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .i_coef_we    (i_coef_we),
    .i_coef_addr  (i_coef_addr),
    .i_coef_wdata (i_coef_wdata),
    .i_clear      (i_clear),
    .o_sat        (o_sat)
  );

  typedef struct {
    logic        clr;
    logic        wr;
    logic        wr_same;
    logic [7:0]  wa;
    logic [23:0] wd;
    logic [23:0] din;
    logic [23:0] dout;
    logic        sat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic coef_write(input logic [7:0] wa, input logic [23:0] wd);
    @(negedge i_clk);
    i_coef_we = 1'b1; i_coef_addr = wa; i_coef_wdata = wd;
    @(negedge i_clk);
    i_coef_we = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge i_clk);
    i_clear = 1'b1; i_valid = 1'b1; i_data = 24'h111111;
    #1 check("in_ready_during_clear", 32'(o_in_ready), 32'd0);
    @(negedge i_clk);
    i_clear = 1'b0; i_valid = 1'b0;
    #1 check("idle_after_clear", 32'(o_in_ready), 32'd1);
  endtask

  // Handshake one sample, then wait (bounded) for o_valid; leaves the bench at OUT.
  task automatic send(input logic [23:0] din, input logic wr_same, input logic [7:0] wa,
                      input logic [23:0] wd, output int lat);
    @(negedge i_clk);
    i_valid = 1'b1; i_data = din;
    if (wr_same) begin
      i_coef_we = 1'b1; i_coef_addr = wa; i_coef_wdata = wd;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_coef_we = 1'b0;
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    logic [23:0] held;

    //           clr   wr    same  addr   wdata      din        dout       sat
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,  24'h000000, 24'h100000, 24'h100000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0,  24'h200000, 24'h200000, 24'h100000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd3,  24'hE00000, 24'h000000, 24'h000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'd0,  24'h400000, 24'h100000, 24'h100000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0,  24'h000000, 24'h000000, 24'h080000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0,  24'h000000, 24'h000000, 24'h040000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0,  24'h000000, 24'h000000, 24'h000000, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd3,  24'h000000, 24'h000000, 24'h000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd0,  24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd0,  24'h000000, 24'h800000, 24'h800000, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd20, 24'h000000, 24'h200000, 24'h3FFFFF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd5,  24'h200000, 24'h200000, 24'h1FFFFF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd0,  24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_sat", 32'(o_sat), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd1);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].clr) do_clear();
      if (vecs[v].wr && !vecs[v].wr_same) coef_write(vecs[v].wa, vecs[v].wd);
      send(vecs[v].din, vecs[v].wr_same, vecs[v].wa, vecs[v].wd, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd24);
      check($sformatf("vec%0d_data", v), 32'(o_data), 32'(vecs[v].dout));
      check($sformatf("vec%0d_sat", v), 32'(o_sat), 32'(vecs[v].sat));
      @(posedge i_clk);
      #1;
    end

    // Output stall: data held, no acceptance, coefficient write ignored.
    i_ready = 1'b0;
    send(24'h200000, 1'b0, 8'd0, 24'd0, lat);
    check("stall_latency", 32'(lat), 32'd24);
    check("stall_data", 32'(o_data), 32'h1FFFFF);
    held = o_data;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_data = 24'h555555;
      i_coef_we = 1'b1; i_coef_addr = 8'd0; i_coef_wdata = 24'h400000;
      #1;
      if (o_data !== held || o_in_ready !== 1'b0 || o_valid !== 1'b1) bad++;
    end
    check("stall_hold_violations", 32'(bad), 32'd0);
    @(negedge i_clk);
    i_ready = 1'b1; i_valid = 1'b0; i_coef_we = 1'b0;
    @(posedge i_clk);
    #1;
    check("release_o_valid", 32'(o_valid), 32'd0);
    check("release_in_ready", 32'(o_in_ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) bad++;
    end
    check("no_second_accept", 32'(bad), 32'd0);
    send(24'h200000, 1'b0, 8'd0, 24'd0, lat);
    check("stall_write_ignored", 32'(o_data), 32'h1FFFFF);
    @(posedge i_clk);
    #1;

    // Reset mid-flight aborts the sample and restores passthrough coefficients.
    @(negedge i_clk);
    i_valid = 1'b1; i_data = 24'h200000;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("abort_o_data", 32'(o_data), 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) bad++;
    end
    check("abort_no_output", 32'(bad), 32'd0);
    send(24'h123456, 1'b0, 8'd0, 24'd0, lat);
    check("post_rst_latency", 32'(lat), 32'd24);
    check("post_rst_data", 32'(o_data), 32'h123456);
    check("post_rst_sat", 32'(o_sat), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
